// File: rtl/rsa_pkg.sv
// Shared types and default sizing for the serial chunk adder.
package rsa_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_DONE
   } state_t;

   localparam int DEF_WIDTH = 32;
   localparam int DEF_CHUNK = 8;

endpackage

// File: rtl/chunk_adder.sv
// Combinational CHUNK-bit adder with carry in/out; one slice of the serial datapath.
module chunk_adder #(
   parameter int CHUNK = 8
) (
   input  logic [CHUNK-1:0] a,
   input  logic [CHUNK-1:0] b,
   input  logic             ci,
   output logic [CHUNK-1:0] sum,
   output logic             co
);

   assign {co, sum} = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, ci};

endmodule

// File: rtl/serial_chunk_adder.sv
// Multi-cycle adder/subtractor processing CHUNK bits per clock, LSB chunk first.
// Subtraction is enabled by defining SERIAL_CHUNK_ADDER_SUB_EN; otherwise op_sub is ignored.
module serial_chunk_adder
   import rsa_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int CHUNK = DEF_CHUNK
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             op_sub,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             co
);

   localparam int N  = (CHUNK >= 1) ? WIDTH / CHUNK : 1;
   localparam int CW = (N == 1) ? 1 : $clog2(N) + 1;

   generate
      if (CHUNK < 1 || (WIDTH % ((CHUNK >= 1) ? CHUNK : 1)) != 0) begin : g_bad_cfg
         $error("serial_chunk_adder: WIDTH must be a positive multiple of CHUNK");
      end
   endgenerate

   state_t          state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             carry_q, carry_d;
   logic             co_q, co_d;

   logic [CHUNK-1:0] ch_sum;
   logic             ch_co;
   logic             sub_en;

`ifdef SERIAL_CHUNK_ADDER_SUB_EN
   assign sub_en = op_sub;
`else
   logic unused_op_sub;
   assign unused_op_sub = op_sub;
   assign sub_en        = 1'b0;
`endif

   // Operands shift right each RUN cycle, so the active chunk is always the low slice.
   chunk_adder #(.CHUNK(CHUNK)) u_chunk_adder (
      .a   (a_q[CHUNK-1:0]),
      .b   (b_q[CHUNK-1:0]),
      .ci  (carry_q),
      .sum (ch_sum),
      .co  (ch_co)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         cnt_q   <= '0;
         carry_q <= 1'b0;
         co_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sum_q   <= sum_d;
         cnt_q   <= cnt_d;
         carry_q <= carry_d;
         co_q    <= co_d;
      end
   end

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      sum_d   = sum_q;
      cnt_d   = cnt_q;
      carry_d = carry_q;
      co_d    = co_q;

      unique case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               state_d = ST_RUN;
               a_d     = a;
               b_d     = sub_en ? ~b : b;
               carry_d = sub_en;
               cnt_d   = '0;
            end else if (state_q == ST_DONE) begin
               state_d = ST_IDLE;
            end
         end
         ST_RUN: begin
            sum_d[cnt_q*CHUNK +: CHUNK] = ch_sum;
            carry_d = ch_co;
            a_d     = a_q >> CHUNK;
            b_d     = b_q >> CHUNK;
            if (cnt_q == CW'(N - 1)) begin
               state_d = ST_DONE;
               co_d    = ch_co;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign busy = (state_q == ST_RUN);
   assign done = (state_q == ST_DONE);
   assign sum  = sum_q;
   assign co   = co_q;

endmodule

// File: tb/tb_serial_chunk_adder.sv
// Self-checking bench: 32/8 and 8/8 instances against an arithmetic reference model.
module tb_serial_chunk_adder;

`ifdef SERIAL_CHUNK_ADDER_SUB_EN
   localparam bit SUB_EN = 1'b1;
`else
   localparam bit SUB_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start_w, start_n, op_sub;
   logic [31:0] a, b;
   logic        busy_w, done_w, co_w;
   logic [31:0] sum_w;
   logic        busy_n, done_n, co_n;
   logic [7:0]  sum_n;
   int unsigned checks = 0;
   int unsigned errors = 0;
   logic [32:0] r;

   always #5 clk = ~clk;

   serial_chunk_adder #(.WIDTH(32), .CHUNK(8)) u_dut (
      .clk(clk), .rst_n(rst_n), .start(start_w), .op_sub(op_sub),
      .a(a), .b(b), .busy(busy_w), .done(done_w), .sum(sum_w), .co(co_w)
   );

   serial_chunk_adder #(.WIDTH(8), .CHUNK(8)) u_dut8 (
      .clk(clk), .rst_n(rst_n), .start(start_n), .op_sub(op_sub),
      .a(a[7:0]), .b(b[7:0]), .busy(busy_n), .done(done_n), .sum(sum_n), .co(co_n)
   );

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic obs_busy(input bit nar);
      return nar ? busy_n : busy_w;
   endfunction
   function automatic logic obs_done(input bit nar);
      return nar ? done_n : done_w;
   endfunction
   function automatic logic [31:0] obs_sum(input bit nar);
      return nar ? {24'h0, sum_n} : sum_w;
   endfunction
   function automatic logic obs_co(input bit nar);
      return nar ? co_n : co_w;
   endfunction

   // Reference: {co, sum} from plain modular arithmetic
   function automatic logic [32:0] model(input bit nar, input logic [31:0] va, input logic [31:0] vb,
                                         input bit sub);
      logic [32:0] full;
      logic [31:0] mask, ma, mb;
      mask = nar ? 32'h0000_00FF : 32'hFFFF_FFFF;
      ma   = va & mask;
      mb   = vb & mask;
      if (sub && SUB_EN) begin
         return {(ma >= mb), (ma - mb) & mask};
      end
      full = {1'b0, ma} + {1'b0, mb};
      return {(nar ? full[8] : full[32]), full[31:0] & mask};
   endfunction

   // Entered just after an edge in IDLE or DONE; returns just after the completing edge.
   task automatic run_op(input bit nar, input logic [31:0] va, input logic [31:0] vb, input bit sub,
                         input bit poke, input string tag, output logic [32:0] res);
      int n;
      logic [32:0] exp;
      n   = nar ? 1 : 4;
      exp = model(nar, va, vb, sub);
      a = va; b = vb; op_sub = sub;
      if (nar) start_n = 1'b1; else start_w = 1'b1;
      @(posedge clk); #1;
      start_w = 1'b0; start_n = 1'b0;
      a = $urandom; b = $urandom; op_sub = 1'($urandom_range(0, 1));
      check_eq({tag, ".busy0"}, 64'(obs_busy(nar)), 64'd1);
      check_eq({tag, ".done0"}, 64'(obs_done(nar)), 64'd0);
      for (int k = 1; k <= n; k++) begin
         @(posedge clk); #1;
         start_w = 1'b0;
         if (k < n) begin
            check_eq($sformatf("%s.busy%0d", tag, k), 64'(obs_busy(nar)), 64'd1);
            check_eq($sformatf("%s.done%0d", tag, k), 64'(obs_done(nar)), 64'd0);
            if (poke && !nar && k == 1) begin
               start_w = 1'b1; a = $urandom; b = $urandom; op_sub = ~sub;
            end
         end else begin
            check_eq({tag, ".done"}, 64'(obs_done(nar)), 64'd1);
            check_eq({tag, ".busyN"}, 64'(obs_busy(nar)), 64'd0);
            check_eq({tag, ".sum"}, 64'(obs_sum(nar)), 64'(exp[31:0]));
            check_eq({tag, ".co"}, 64'(obs_co(nar)), 64'(exp[32]));
         end
      end
      res = exp;
   endtask

   task automatic idle_check(input bit nar, input logic [32:0] exp, input string tag);
      @(posedge clk); #1;
      check_eq({tag, ".idle_done"}, 64'(obs_done(nar)), 64'd0);
      check_eq({tag, ".idle_busy"}, 64'(obs_busy(nar)), 64'd0);
      check_eq({tag, ".hold_sum"}, 64'(obs_sum(nar)), 64'(exp[31:0]));
      check_eq({tag, ".hold_co"}, 64'(obs_co(nar)), 64'(exp[32]));
   endtask

   initial begin
      bit nar;
      start_w = 1'b0; start_n = 1'b0; op_sub = 1'b0; a = '0; b = '0;
      repeat (3) @(posedge clk);
      #1;
      check_eq("rst.busy", 64'(busy_w), 64'd0);
      check_eq("rst.done", 64'(done_w), 64'd0);
      check_eq("rst.sum", 64'(sum_w), 64'd0);
      check_eq("rst.co", 64'(co_w), 64'd0);
      check_eq("rst.sum8", 64'(sum_n), 64'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      run_op(1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, "ovf", r);
      idle_check(1'b0, r, "ovf");
      run_op(1'b0, 32'h0000_0005, 32'h0000_0007, 1'b1, 1'b0, "sub5_7", r);
      idle_check(1'b0, r, "sub5_7");
      run_op(1'b0, 32'h0000_0007, 32'h0000_0005, 1'b1, 1'b0, "sub7_5", r);
      idle_check(1'b0, r, "sub7_5");
      run_op(1'b0, 32'hA5A5_1234, 32'h0F0F_FFFF, 1'b0, 1'b1, "ignore", r);
      idle_check(1'b0, r, "ignore");

      run_op(1'b0, $urandom, $urandom, 1'b1, 1'b0, "b2b_first", r);
      run_op(1'b0, 32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, "b2b", r);
      check_eq("b2b.model", 64'(r), 64'h0_2345_6789);
      idle_check(1'b0, r, "b2b");

      // Reset asserted between edges 2 and 3 of an operation
      a = 32'hDEAD_BEEF; b = 32'h0123_4567; op_sub = 1'b0; start_w = 1'b1;
      @(posedge clk); #1;
      start_w = 1'b0;
      @(posedge clk);
      @(posedge clk); #2;
      rst_n = 1'b0;
      #1;
      check_eq("mid_rst.busy", 64'(busy_w), 64'd0);
      check_eq("mid_rst.done", 64'(done_w), 64'd0);
      check_eq("mid_rst.sum", 64'(sum_w), 64'd0);
      check_eq("mid_rst.co", 64'(co_w), 64'd0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      for (int k = 0; k < 6; k++) begin
         @(posedge clk); #1;
         check_eq($sformatf("mid_rst.nodone%0d", k), 64'(done_w), 64'd0);
         check_eq($sformatf("mid_rst.nobusy%0d", k), 64'(busy_w), 64'd0);
      end

      run_op(1'b0, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, "post_rst", r);
      idle_check(1'b0, r, "post_rst");

      run_op(1'b1, 32'h80, 32'h80, 1'b0, 1'b0, "n1_add", r);
      idle_check(1'b1, r, "n1_add");
      run_op(1'b1, 32'h80, 32'h80, 1'b1, 1'b0, "n1_sub", r);
      idle_check(1'b1, r, "n1_sub");

      for (int i = 0; i < 24; i++) begin
         nar = (i % 4 == 3);
         run_op(nar, $urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                $sformatf("rnd%0d", i), r);
         if ($urandom_range(0, 2) != 0) idle_check(nar, r, $sformatf("rnd%0d", i));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
